// File: rtl/sap_prog_loader.sv
// SAP-1 program loader: accepts a framed host byte stream, writes the payload into
// the 16x8 RAM and releases the CPU from clear only after the checksum verifies.
module sap_prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       ram_we,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       cpu_clr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_SYNC, S_LEN, S_ADDR, S_DATA, S_WR, S_CHK, S_RUN, S_ERR
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] sum, sum_nxt, sum_chk, timer;
    logic [4:0] count, count_nxt;
    logic [3:0] addr, addr_nxt;
    logic       accept, waiting, timeout, err_nxt, done_nxt;

    assign in_ready = !clr && (state != S_WR);
    assign accept   = in_valid && in_ready;
    assign ram_we   = (state == S_WR);
    assign cpu_clr  = (state != S_RUN);
    assign waiting  = (state == S_LEN) || (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
    assign busy     = waiting || (state == S_WR);
    assign sum_chk  = sum + in_data;
    // Timer holds the idle cycles already seen; this cycle would be the TIMEOUT-th.
    assign timeout  = waiting && !accept && (timer + 8'd1 == TMO);

    always_comb begin
        state_nxt = state;
        sum_nxt   = sum;
        count_nxt = count;
        addr_nxt  = addr;
        err_nxt   = err;
        done_nxt  = 1'b0;
        case (state)
            S_SYNC, S_RUN, S_ERR: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_nxt = S_LEN;
                    sum_nxt   = 8'd0;
                    err_nxt   = 1'b0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (in_data == 8'd0 || in_data > 8'd16) begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        count_nxt = in_data[4:0];
                        sum_nxt   = sum_chk;
                        state_nxt = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_nxt  = in_data[3:0];
                    sum_nxt   = sum_chk;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    sum_nxt   = sum_chk;
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                addr_nxt  = addr + 4'd1;
                count_nxt = count - 5'd1;
                state_nxt = (count == 5'd1) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (accept) begin
                    if (sum_chk == 8'd0) begin
                        state_nxt = S_RUN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = S_SYNC;
        endcase
        if (timeout) begin
            state_nxt = S_ERR;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_SYNC;
            sum       <= 8'd0;
            count     <= 5'd0;
            addr      <= 4'd0;
            timer     <= 8'd0;
            err       <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= 4'd0;
            ram_wdata <= 8'd0;
        end else begin
            state <= state_nxt;
            sum   <= sum_nxt;
            count <= count_nxt;
            addr  <= addr_nxt;
            err   <= err_nxt;
            done  <= done_nxt;
            timer <= (accept || !waiting || state_nxt != state) ? 8'd0 : timer + 8'd1;
            if (state == S_DATA && accept) begin
                ram_addr  <= addr;
                ram_wdata <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_sap_prog_loader.sv
// Randomized frame bench for sap_prog_loader; expected writes and outcomes come
// from a byte-list frame parser kept in the bench.
module tb_sap_prog_loader;

    localparam int TMO = 4;

    typedef logic [7:0]  bq_t[$];
    typedef logic [11:0] wq_t[$];

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready, ram_we, cpu_clr, busy, done, err;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;

    int n_chk = 0;
    int n_fail = 0;

    logic [11:0] wr_q[$];
    int          done_cnt = 0;

    always #5 clk = ~clk;

    sap_prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .cpu_clr(cpu_clr), .busy(busy),
        .done(done), .err(err)
    );

    // RAM-side monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_we) wr_q.push_back({ram_addr, ram_wdata});
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame parser: expected write list and outcome (0 = loaded, 1 = error).
    function automatic void ref_model(input bq_t f, output wq_t w, output int res);
        logic [7:0] s;
        logic [3:0] a;
        int n;
        w = {};
        res = 1;
        if (f.size() < 2) return;
        n = int'(f[1]);
        if (n < 1 || n > 16) return;
        if (f.size() < n + 4) return;
        a = f[2][3:0];
        s = f[1] + f[2];
        for (int i = 0; i < n; i++) begin
            w.push_back({a, f[3+i]});
            s = s + f[3+i];
            a = a + 4'd1;
        end
        s = s + f[3+n];
        res = (s == 8'd0) ? 0 : 1;
    endfunction

    function automatic bq_t mk_frame(input int len, input logic [7:0] start, input bit ok);
        bq_t f;
        logic [7:0] s;
        f = {8'hA5, 8'(len), start};
        s = 8'(len) + start;
        for (int i = 0; i < len; i++) begin
            f.push_back(8'($urandom));
            s = s + f[f.size()-1];
        end
        f.push_back(8'(8'd0 - s) + (ok ? 8'd0 : 8'($urandom_range(255, 1))));
        return f;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_wait", 32'(in_ready), 32'd1);
        else @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input bq_t f, input int gap_max);
        wq_t w;
        int  res;
        int  base = wr_q.size();
        int  d0 = done_cnt;
        ref_model(f, w, res);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
        end
        idle(3);
        chk("wr_count", 32'(wr_q.size() - base), 32'(w.size()));
        for (int i = 0; i < w.size() && base + i < wr_q.size(); i++)
            chk("wr_data", 32'(wr_q[base+i]), 32'(w[i]));
        chk("done_pulses", 32'(done_cnt - d0), 32'(res == 0));
        chk("err", 32'(err), 32'(res != 0));
        chk("cpu_clr", 32'(cpu_clr), 32'(res != 0));
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int base, k, kind, len;
        logic [7:0] g;

        // reset values while clr held
        idle(2);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_cpu_clr", 32'(cpu_clr), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        clr = 1'b0;
        idle(1);

        // directed frames
        send_byte(8'h00);
        send_byte(8'hFF);
        chk("garbage_busy", 32'(busy), 32'd0);
        run_frame('{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33, 8'h95}, 0);
        run_frame('{8'hA5, 8'h02, 8'h0F, 8'hAA, 8'hBB, 8'h8A}, 0);
        run_frame('{8'hA5, 8'h01, 8'h00, 8'h55, 8'h00}, 0);
        run_frame('{8'hA5, 8'h01, 8'h07, 8'h10, 8'hE8}, 0);
        run_frame('{8'hA5, 8'h00}, 0);
        run_frame('{8'hA5, 8'h11}, 0);
        run_frame(mk_frame(16, 8'h3C, 1'b1), 1);

        // inter-byte timeout
        base = wr_q.size();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h77);
        idle(2);
        chk("tmo_early_err", 32'(err), 32'd0);
        k = 0;
        while (!err && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_cpu_clr", 32'(cpu_clr), 32'd1);
        chk("tmo_wr_count", 32'(wr_q.size() - base), 32'd1);
        if (wr_q.size() > base) chk("tmo_wr_data", 32'(wr_q[base]), 32'h077);

        // re-arm from RUN
        run_frame(mk_frame(3, 8'h08, 1'b1), 0);
        send_byte(8'hA5);
        chk("rearm_cpu_clr", 32'(cpu_clr), 32'd1);
        chk("rearm_busy", 32'(busy), 32'd1);

        // clr mid-DATA
        send_byte(8'h04);
        send_byte(8'h05);
        send_byte(8'h10);
        send_byte(8'h20);
        idle(1);
        base = wr_q.size();
        #2 clr = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_ram_we", 32'(ram_we), 32'd0);
        chk("abort_cpu_clr", 32'(cpu_clr), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_addr", 32'(ram_addr), 32'd0);
        chk("abort_wdata", 32'(ram_wdata), 32'd0);
        idle(3);
        chk("abort_no_wr", 32'(wr_q.size() - base), 32'd0);
        clr = 1'b0;
        idle(1);

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(2, 0)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g);
            end
            kind = $urandom_range(7, 0);
            if (kind == 0) begin
                len = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(255, 17);
                run_frame('{8'hA5, 8'(len)}, 2);
            end else begin
                run_frame(mk_frame($urandom_range(16, 1), 8'($urandom), kind != 1), 2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
